// File: rtl/ex_alu_stage_pkg.sv
// rtl/ex_alu_stage_pkg.sv - aluctrl codes and EX-stage FSM state shared with ALU control
package ex_alu_stage_pkg;

  localparam logic [3:0] ALU_AND = 4'd0;
  localparam logic [3:0] ALU_OR  = 4'd1;
  localparam logic [3:0] ALU_ADD = 4'd2;
  localparam logic [3:0] ALU_MUL = 4'd4;
  localparam logic [3:0] ALU_SUB = 4'd6;
  localparam logic [3:0] ALU_SLT = 4'd7;
  localparam logic [3:0] ALU_NOR = 4'd12;
  localparam logic [3:0] ALU_BAD = 4'd15;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } ex_state_t;

endpackage

// File: rtl/ex_alu_stage_alu_comb.sv
// rtl/ex_alu_stage_alu_comb.sv - single-cycle combinational ALU datapath
module alu_comb
  import ex_alu_stage_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [3:0]       aluctrl,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             overflow,
  output logic             illegal
);

  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;

  assign sum  = a + b;
  assign diff = a - b;

  // MUL is a legal code but its result comes from the iterative unit in the top.
  always_comb begin
    result   = '0;
    overflow = 1'b0;
    illegal  = 1'b0;
    case (aluctrl)
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_ADD: begin
        result   = sum;
        overflow = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      ALU_SUB: begin
        result   = diff;
        overflow = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      ALU_SLT: result = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_NOR: result = ~(a | b);
      ALU_MUL: result = '0;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/ex_alu_stage.sv
// rtl/ex_alu_stage.sv - execute-stage ALU with iterative MUL and EX/MEM register
module ex_alu_stage
  import ex_alu_stage_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [3:0]       aluctrl,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  input  logic [4:0]       in_rd,
  input  logic             in_regwrite,
  input  logic             stall_in,
  input  logic             flush,
  output logic             busy,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_result,
  output logic             out_zero,
  output logic             out_overflow,
  output logic             out_illegal,
  output logic [4:0]       out_rd,
  output logic             out_regwrite
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  ex_state_t        state;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_next;
  logic [4:0]       mul_rd;
  logic             mul_regwrite;
  logic             accept;

  logic [WIDTH-1:0] comb_result;
  logic             comb_overflow;
  logic             comb_illegal;

  alu_comb #(.WIDTH(WIDTH)) u_alu_comb (
    .aluctrl  (aluctrl),
    .a        (opa),
    .b        (opb),
    .result   (comb_result),
    .overflow (comb_overflow),
    .illegal  (comb_illegal)
  );

  assign busy     = (state == ST_MUL);
  assign accept   = in_valid & ~busy & ~stall_in & ~flush;
  assign acc_next = mplier[0] ? (acc + mcand) : acc;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      count        <= '0;
      mcand        <= '0;
      mplier       <= '0;
      acc          <= '0;
      mul_rd       <= '0;
      mul_regwrite <= 1'b0;
      out_valid    <= 1'b0;
      out_result   <= '0;
      out_zero     <= 1'b0;
      out_overflow <= 1'b0;
      out_illegal  <= 1'b0;
      out_rd       <= '0;
      out_regwrite <= 1'b0;
    end else if (flush) begin
      state        <= ST_IDLE;
      count        <= '0;
      out_valid    <= 1'b0;
      out_result   <= '0;
      out_zero     <= 1'b0;
      out_overflow <= 1'b0;
      out_illegal  <= 1'b0;
      out_rd       <= '0;
      out_regwrite <= 1'b0;
    end else if (!stall_in) begin
      // Bubble unless overridden below by a completing op.
      out_valid    <= 1'b0;
      out_result   <= '0;
      out_zero     <= 1'b0;
      out_overflow <= 1'b0;
      out_illegal  <= 1'b0;
      out_rd       <= '0;
      out_regwrite <= 1'b0;
      if (state == ST_MUL) begin
        acc    <= acc_next;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        count  <= count - CNT_ONE;
        if (count == CNT_ONE) begin
          state        <= ST_IDLE;
          out_valid    <= 1'b1;
          out_result   <= acc_next;
          out_zero     <= (acc_next == '0);
          out_rd       <= mul_rd;
          out_regwrite <= mul_regwrite;
        end
      end else if (accept) begin
        if (aluctrl == ALU_MUL) begin
          state        <= ST_MUL;
          count        <= CNT_LOAD;
          mcand        <= opa;
          mplier       <= opb;
          acc          <= '0;
          mul_rd       <= in_rd;
          mul_regwrite <= in_regwrite;
        end else begin
          out_valid    <= 1'b1;
          out_result   <= comb_result;
          out_zero     <= (comb_result == '0);
          out_overflow <= comb_overflow;
          out_illegal  <= comb_illegal;
          out_rd       <= in_rd;
          out_regwrite <= in_regwrite & ~comb_illegal;
        end
      end
    end
  end

endmodule

// File: tb/tb_ex_alu_stage.sv
// tb/tb_ex_alu_stage.sv - scoreboard bench for ex_alu_stage
module tb_ex_alu_stage;

  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic [3:0]       aluctrl;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic [4:0]       in_rd;
  logic             in_regwrite;
  logic             stall_in;
  logic             flush;
  logic             busy;
  logic             out_valid;
  logic [WIDTH-1:0] out_result;
  logic             out_zero;
  logic             out_overflow;
  logic             out_illegal;
  logic [4:0]       out_rd;
  logic             out_regwrite;

  ex_alu_stage #(.WIDTH(WIDTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .aluctrl      (aluctrl),
    .opa          (opa),
    .opb          (opb),
    .in_rd        (in_rd),
    .in_regwrite  (in_regwrite),
    .stall_in     (stall_in),
    .flush        (flush),
    .busy         (busy),
    .out_valid    (out_valid),
    .out_result   (out_result),
    .out_zero     (out_zero),
    .out_overflow (out_overflow),
    .out_illegal  (out_illegal),
    .out_rd       (out_rd),
    .out_regwrite (out_regwrite)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] result;
    logic        zero;
    logic        ovf;
    logic        ill;
    logic [4:0]  rd;
    logic        rw;
  } exp_t;

  exp_t sbq[$];
  exp_t last_exp;
  int   total = 0;
  int   bad = 0;
  int   mul_left = 0;
  logic exp_valid = 1'b0;
  logic exp_hold = 1'b0;
  logic mon_en = 1'b0;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, req, $time);
    end
  endfunction

  function automatic exp_t model(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                                 input logic [4:0] rd, input logic rw);
    exp_t e;
    longint sa;
    longint sb;
    longint s;
    longint unsigned p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    s = 0;
    p = 0;
    e.result = '0;
    e.ovf = 1'b0;
    e.ill = 1'b0;
    case (c)
      4'd0:  e.result = a & b;
      4'd1:  e.result = a | b;
      4'd2: begin
        s = sa + sb;
        e.result = s[31:0];
        e.ovf = (s != longint'($signed(s[31:0])));
      end
      4'd6: begin
        s = sa - sb;
        e.result = s[31:0];
        e.ovf = (s != longint'($signed(s[31:0])));
      end
      4'd7:  e.result = (sa < sb) ? 32'd1 : 32'd0;
      4'd12: e.result = ~(a | b);
      4'd4: begin
        p = longint'({32'b0, a}) * longint'({32'b0, b});
        e.result = p[31:0];
      end
      default: e.ill = 1'b1;
    endcase
    e.zero = (e.result == 32'd0);
    e.rd = rd;
    e.rw = e.ill ? 1'b0 : rw;
    return e;
  endfunction

  task automatic step(input logic v, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                      input logic [4:0] rd, input logic rw, input logic st, input logic fl,
                      input logic rs);
    in_valid = v; aluctrl = c; opa = a; opb = b; in_rd = rd; in_regwrite = rw;
    stall_in = st; flush = fl; reset = rs;
    @(posedge clk);
    if (rs) begin
      mul_left = 0; sbq.delete(); exp_valid = 1'b0; exp_hold = 1'b0;
    end else if (fl) begin
      if (mul_left > 0 && sbq.size() > 0) void'(sbq.pop_back());
      mul_left = 0; exp_valid = 1'b0; exp_hold = 1'b0;
    end else if (st) begin
      exp_hold = 1'b1;
    end else begin
      exp_hold = 1'b0;
      if (mul_left > 0) begin
        exp_valid = (mul_left == 1);
        mul_left--;
      end else if (v) begin
        sbq.push_back(model(c, a, b, rd, rw));
        if (c == 4'd4) begin
          mul_left = WIDTH;
          exp_valid = 1'b0;
        end else begin
          exp_valid = 1'b1;
        end
      end else begin
        exp_valid = 1'b0;
      end
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 4'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  function automatic logic [31:0] pick_op();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'h7FFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  always @(negedge clk) begin
    if (mon_en) begin
      check("busy", {63'd0, busy}, {63'd0, (mul_left > 0)});
      check("out_valid", {63'd0, out_valid}, {63'd0, exp_valid});
      if (out_valid && exp_valid) begin
        if (!exp_hold) begin
          check("sb_avail", 64'(sbq.size() > 0), 64'd1);
          if (sbq.size() > 0) last_exp = sbq.pop_front();
        end
        check("result", {32'd0, out_result}, {32'd0, last_exp.result});
        check("zero", {63'd0, out_zero}, {63'd0, last_exp.zero});
        check("overflow", {63'd0, out_overflow}, {63'd0, last_exp.ovf});
        check("illegal", {63'd0, out_illegal}, {63'd0, last_exp.ill});
        check("rd", {59'd0, out_rd}, {59'd0, last_exp.rd});
        check("regwrite", {63'd0, out_regwrite}, {63'd0, last_exp.rw});
      end
    end
  end

  initial begin
    logic [3:0] codes [10];
    codes = '{4'd0, 4'd1, 4'd2, 4'd4, 4'd6, 4'd7, 4'd12, 4'd2, 4'd6, 4'd9};

    step(1'b0, 4'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 4'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_valid", {63'd0, out_valid}, 64'd0);
    check("rst_result", {32'd0, out_result}, 64'd0);
    check("rst_zero", {63'd0, out_zero}, 64'd0);
    check("rst_ovf", {63'd0, out_overflow}, 64'd0);
    check("rst_ill", {63'd0, out_illegal}, 64'd0);
    check("rst_rd", {59'd0, out_rd}, 64'd0);
    check("rst_rw", {63'd0, out_regwrite}, 64'd0);
    mon_en = 1'b1;

    // Single-cycle directed ops
    step(1'b1, 4'd2, 32'h7FFF_FFFF, 32'd1, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0);
    check("add_ovf_res", {32'd0, out_result}, 64'h8000_0000);
    check("add_ovf_flag", {63'd0, out_overflow}, 64'd1);
    check("add_ovf_zero", {63'd0, out_zero}, 64'd0);
    step(1'b1, 4'd6, 32'd5, 32'd5, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0);
    check("sub_res", {32'd0, out_result}, 64'd0);
    check("sub_zero", {63'd0, out_zero}, 64'd1);
    step(1'b1, 4'd7, 32'hFFFF_FFFF, 32'd1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    check("slt_res", {32'd0, out_result}, 64'd1);
    step(1'b1, 4'd12, 32'd0, 32'd0, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0);
    check("nor_res", {32'd0, out_result}, 64'hFFFF_FFFF);

    // MUL timing
    step(1'b1, 4'd4, 32'h0001_0003, 32'd5, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
    check("mul_busy_start", {63'd0, busy}, 64'd1);
    for (int i = 1; i <= WIDTH; i++) begin
      idle(1);
      if (i < WIDTH) begin
        check("mul_bubble", {63'd0, out_valid}, 64'd0);
      end else begin
        check("mul_res", {32'd0, out_result}, 64'h0005_000F);
        check("mul_done_valid", {63'd0, out_valid}, 64'd1);
        check("mul_done_busy", {63'd0, busy}, 64'd0);
      end
    end

    // MUL with a 3-cycle stall mid-way, then a stall while the result is held
    step(1'b1, 4'd4, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(10);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 4'd2, 32'd1, 32'd1, 5'd1, 1'b1, 1'b1, 1'b0, 1'b0);
      check("stall_busy", {63'd0, busy}, 64'd1);
    end
    idle(21);
    check("stall_not_yet", {63'd0, out_valid}, 64'd0);
    idle(1);
    check("stall_mul_res", {32'd0, out_result}, 64'd1);
    step(1'b1, 4'd2, 32'd9, 32'd9, 5'd1, 1'b1, 1'b1, 1'b0, 1'b0);
    check("frozen_res", {32'd0, out_result}, 64'd1);
    check("frozen_valid", {63'd0, out_valid}, 64'd1);

    // Flush at cycle N+10 of a MUL, then ADD
    step(1'b1, 4'd4, 32'd1234, 32'd5678, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(9);
    step(1'b0, 4'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("flush_busy", {63'd0, busy}, 64'd0);
    check("flush_valid", {63'd0, out_valid}, 64'd0);
    step(1'b1, 4'd2, 32'd2, 32'd3, 5'd10, 1'b1, 1'b0, 1'b0, 1'b0);
    check("post_flush_add", {32'd0, out_result}, 64'd5);
    check("post_flush_valid", {63'd0, out_valid}, 64'd1);
    idle(40);

    // Illegal code
    step(1'b1, 4'd9, 32'h1234, 32'h5678, 5'd11, 1'b1, 1'b0, 1'b0, 1'b0);
    check("ill_flag", {63'd0, out_illegal}, 64'd1);
    check("ill_res", {32'd0, out_result}, 64'd0);
    check("ill_rw", {63'd0, out_regwrite}, 64'd0);
    check("ill_valid", {63'd0, out_valid}, 64'd1);

    // Reset mid-MUL
    step(1'b1, 4'd4, 32'd77, 32'd99, 5'd12, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(5);
    step(1'b0, 4'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("mrst_busy", {63'd0, busy}, 64'd0);
    check("mrst_valid", {63'd0, out_valid}, 64'd0);
    check("mrst_result", {32'd0, out_result}, 64'd0);
    check("mrst_rd", {59'd0, out_rd}, 64'd0);
    check("mrst_rw", {63'd0, out_regwrite}, 64'd0);

    // Randomized traffic
    for (int n = 0; n < 2500; n++) begin
      logic [3:0] c;
      c = codes[$urandom_range(0, 9)];
      if (c == 4'd9) c = 4'($urandom_range(0, 15));
      step($urandom_range(0, 9) < 7, c, pick_op(), pick_op(), 5'($urandom),
           1'($urandom), $urandom_range(0, 9) == 0, $urandom_range(0, 29) == 0, 1'b0);
    end

    idle(2 * WIDTH);
    check("sb_drained", 64'(sbq.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
